// File: rtl/prio_encoder_serial_pkg.sv
// prio_enc_pkg: shared types and helpers for the serial priority encoder.
//   state_t         - FSM encoding (IDLE, DRAIN)
//   lowest_set_idx  - index of the lowest set bit of a vector (bit 0 wins)
//   popcount        - number of set bits in a vector
// Helpers operate on a 32-bit container (the widest legal request vector);
// callers zero-extend their vector and cast the result to their own width.
package prio_enc_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [4:0] lowest_set_idx(input logic [MAX_N-1:0] vec);
        logic [4:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (vec[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [5:0] popcount(input logic [MAX_N-1:0] vec);
        logic [5:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            cnt = cnt + 6'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_encoder_serial_if.sv
// prio_encoder_serial_if: request-in / code-out handshake bundle.
//   in_valid, in_req[N-1:0]   producer -> encoder (vector offer)
//   in_ready                  encoder -> producer
//   out_valid, out_code[W-1:0], out_last   encoder -> consumer
//   out_ready                 consumer -> encoder
//   out_cnt[W:0]              encoder -> consumer, only with PRIO_ENC_COUNT_EN
// Modports: slave = encoder side, master = surrounding logic.
interface prio_encoder_serial_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic         out_last;
`ifdef PRIO_ENC_COUNT_EN
    logic [W:0]   out_cnt;

    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_code, out_last, out_cnt
    );
    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_code, out_last, out_cnt
    );
`else
    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_code, out_last
    );
    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_code, out_last
    );
`endif

endinterface

// File: rtl/prio_encoder_serial_comb.sv
// prio_encoder_comb: purely combinational N-to-W priority encoder.
//   vec[N-1:0]  input vector, bit 0 = highest priority
//   idx[W-1:0]  index of the lowest set bit (0 when vec is zero)
//   any         at least one bit of vec is set
module prio_encoder_comb
    import prio_enc_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [MAX_N-1:0] vec_ext;

    always_comb begin
        vec_ext        = '0;
        vec_ext[N-1:0] = vec;
    end

    assign idx = W'(lowest_set_idx(vec_ext));
    assign any = |vec;

endmodule

// File: rtl/prio_encoder_serial.sv
// prio_encoder_serial: captures a multi-hot request vector and emits the
// binary index of every set bit, one per handshake, lowest index first.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     block enable; low freezes state and blocks all handshakes
//   bus    prio_encoder_serial_if.slave (in_valid/in_ready/in_req,
//          out_valid/out_ready/out_code/out_last[/out_cnt])
// Optional: define PRIO_ENC_COUNT_EN to add bus.out_cnt (pending popcount).
module prio_encoder_serial
    import prio_enc_pkg::*;
#(
    parameter int N = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  en,
    prio_encoder_serial_if.slave bus
);

    localparam int W = $clog2(N);

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     pending;
    logic [N-1:0]     pending_nxt;
    logic             rdy_q;
    logic [W-1:0]     idx;
    logic             any;
    logic [MAX_N-1:0] pend_ext;
    logic [W:0]       cnt;
    logic             last;
    logic             capture;
    logic             transfer;

    prio_encoder_comb #(.N(N)) u_enc (
        .vec (pending),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        pend_ext        = '0;
        pend_ext[N-1:0] = pending;
    end

    assign cnt  = (W+1)'(popcount(pend_ext));
    assign last = (cnt == (W+1)'(1));

    // rdy_q keeps in_ready low during reset and for the first edge after
    // release, even though the state register already reads IDLE.
    assign bus.in_ready  = en && rdy_q && (state == IDLE);
    assign bus.out_valid = en && (state == DRAIN) && any;
    assign bus.out_code  = idx;
    assign bus.out_last  = last;
`ifdef PRIO_ENC_COUNT_EN
    assign bus.out_cnt   = cnt;
`endif

    assign capture  = bus.in_ready && bus.in_valid;
    assign transfer = bus.out_valid && bus.out_ready;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                // A zero vector is accepted and dropped without leaving IDLE.
                if (capture && (|bus.in_req)) begin
                    pending_nxt = bus.in_req;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (transfer) begin
                    // The issued bit is always the lowest set bit, so
                    // v & (v - 1) clears exactly that bit.
                    pending_nxt = pending & (pending - N'(1));
                    if (last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prio_encoder_serial.sv
// tb_prio_encoder_serial: self-checking bench for prio_encoder_serial.
// A negedge monitor pushes the expected code sequence of every captured
// vector into a scoreboard queue and pops one entry per observed transfer.
// Table-driven vectors cover the main function; hand-written sequences
// cover reset mid-drain, back-to-back drain, backpressure, enable freeze,
// and a single-bit N=8 instance. Build with +define+PRIO_ENC_COUNT_EN to
// also check out_cnt.
module tb_prio_encoder_serial;

    typedef struct packed {
        logic [1:0] code;
        logic       last;
        logic [2:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic        exp_valid;
        logic [1:0]  exp_code;
        logic        exp_last;
        logic        exp_ready;
        int unsigned exp_n;
    } vec_t;

    logic clk;
    logic rst_n;
    logic en;
    logic en8;

    int   checks;
    int   errors;
    int   xfers;
    exp_t sb[$];

    prio_encoder_serial_if #(.N(4)) bus4 ();
    prio_encoder_serial_if #(.N(8)) bus8 ();

    prio_encoder_serial #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus4.slave)
    );

    prio_encoder_serial #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en8),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard producer and consumer, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en && bus4.in_valid && bus4.in_ready) begin
                int unsigned k;
                exp_t e;
                k = 0;
                for (int unsigned i = 0; i < 4; i++) if (bus4.in_req[i]) k++;
                for (int unsigned i = 0; i < 4; i++) begin
                    if (bus4.in_req[i]) begin
                        e.code = 2'(i);
                        e.last = (k == 1);
                        e.cnt  = 3'(k);
                        sb.push_back(e);
                        k--;
                    end
                end
            end
            if (en && bus4.out_valid && bus4.out_ready) begin
                xfers++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_xfer", 32'(bus4.out_code), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_code", 32'(bus4.out_code), 32'(e.code));
                    chk("sb_last", 32'(bus4.out_last), 32'(e.last));
`ifdef PRIO_ENC_COUNT_EN
                    chk("sb_cnt", 32'(bus4.out_cnt), 32'(e.cnt));
`endif
                end
            end
        end
    end

    // Called in the posedge+1 phase; returns just after the capture edge.
    task automatic send(input logic [3:0] req);
        int unsigned n;
        n = 0;
        while (!bus4.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus4.in_ready) chk("send_timeout", 32'(bus4.in_ready), 32'd1);
        bus4.in_valid = 1'b1;
        bus4.in_req   = req;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (!(sb.size() == 0 && bus4.in_ready) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 32'(sb.size() == 0 && bus4.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   x0;

        vecs[0] = '{4'b1011, 1'b1, 2'd0, 1'b0, 1'b0, 3};
        vecs[1] = '{4'b0110, 1'b1, 2'd1, 1'b0, 1'b0, 2};
        vecs[2] = '{4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1};
        vecs[3] = '{4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1};
        vecs[4] = '{4'b1111, 1'b1, 2'd0, 1'b0, 1'b0, 4};
        vecs[5] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 0};
        vecs[6] = '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 1};

        checks = 0;
        errors = 0;
        xfers  = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        en8    = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_req    = '0;
        bus4.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_req    = '0;
        bus8.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_out_code", 32'(bus4.out_code), 32'd0);
        chk("rst_out_last", 32'(bus4.out_last), 32'd0);
`ifdef PRIO_ENC_COUNT_EN
        chk("rst_out_cnt", 32'(bus4.out_cnt), 32'd0);
`endif
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_early", 32'(bus4.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(bus4.in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            bus4.out_ready = 1'b0;
            x0 = xfers;
            send(vecs[i].req);
            chk($sformatf("t%0d_valid", i), 32'(bus4.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("t%0d_code", i), 32'(bus4.out_code), 32'(vecs[i].exp_code));
            chk($sformatf("t%0d_last", i), 32'(bus4.out_last), 32'(vecs[i].exp_last));
            chk($sformatf("t%0d_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_ready));
            bus4.out_ready = 1'b1;
            wait_idle();
            chk($sformatf("t%0d_nxfer", i), 32'(xfers - x0), 32'(vecs[i].exp_n));
        end

        // Full drain under continuous out_ready
        bus4.out_ready = 1'b1;
        send(4'b1011);
        chk("fd_code0", 32'(bus4.out_code), 32'd0);
        chk("fd_last0", 32'(bus4.out_last), 32'd0);
        @(posedge clk); #1;
        chk("fd_code1", 32'(bus4.out_code), 32'd1);
        chk("fd_last1", 32'(bus4.out_last), 32'd0);
        @(posedge clk); #1;
        chk("fd_code3", 32'(bus4.out_code), 32'd3);
        chk("fd_last3", 32'(bus4.out_last), 32'd1);
        @(posedge clk); #1;
        chk("fd_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("fd_out_valid", 32'(bus4.out_valid), 32'd0);

        // Backpressure
        bus4.out_ready = 1'b0;
        send(4'b0110);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_hold_valid%0d", c), 32'(bus4.out_valid), 32'd1);
            chk($sformatf("bp_hold_code%0d", c), 32'(bus4.out_code), 32'd1);
            chk($sformatf("bp_hold_last%0d", c), 32'(bus4.out_last), 32'd0);
            @(posedge clk); #1;
        end
        bus4.out_ready = 1'b1;
        chk("bp_code1", 32'(bus4.out_code), 32'd1);
        @(posedge clk); #1;
        chk("bp_code2", 32'(bus4.out_code), 32'd2);
        chk("bp_last2", 32'(bus4.out_last), 32'd1);
        @(posedge clk); #1;
        chk("bp_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("bp_out_valid", 32'(bus4.out_valid), 32'd0);

        // Enable freeze
        bus4.out_ready = 1'b0;
        send(4'b1000);
        en = 1'b0;
        bus4.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("fz_in_ready%0d", c), 32'(bus4.in_ready), 32'd0);
            chk($sformatf("fz_out_valid%0d", c), 32'(bus4.out_valid), 32'd0);
            chk($sformatf("fz_code%0d", c), 32'(bus4.out_code), 32'd3);
            @(posedge clk); #1;
        end
        en = 1'b1;
        #1;
        chk("fz_resume_valid", 32'(bus4.out_valid), 32'd1);
        chk("fz_resume_code", 32'(bus4.out_code), 32'd3);
        chk("fz_resume_last", 32'(bus4.out_last), 32'd1);
`ifdef PRIO_ENC_COUNT_EN
        chk("fz_cnt1", 32'(bus4.out_cnt), 32'd1);
`endif
        @(posedge clk); #1;
        chk("fz_done_valid", 32'(bus4.out_valid), 32'd0);
        chk("fz_done_ready", 32'(bus4.in_ready), 32'd1);
`ifdef PRIO_ENC_COUNT_EN
        chk("fz_cnt0", 32'(bus4.out_cnt), 32'd0);
`endif

        // Reset mid-drain
        bus4.out_ready = 1'b1;
        send(4'b1011);
        chk("rm_code0", 32'(bus4.out_code), 32'd0);
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        chk("rm_code1", 32'(bus4.out_code), 32'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rm_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rm_in_ready", 32'(bus4.in_ready), 32'd0);
        chk("rm_out_code", 32'(bus4.out_code), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("rm_rel_early", 32'(bus4.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rm_rel_ready", 32'(bus4.in_ready), 32'd1);
        chk("rm_rel_valid", 32'(bus4.out_valid), 32'd0);

        // Single high bit on the N=8 instance
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in_req    = 8'b1000_0000;
        @(posedge clk); #1;
        bus8.in_valid  = 1'b0;
        chk("n8_valid", 32'(bus8.out_valid), 32'd1);
        chk("n8_code", 32'(bus8.out_code), 32'd7);
        chk("n8_last", 32'(bus8.out_last), 32'd1);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("n8_done_valid", 32'(bus8.out_valid), 32'd0);
        chk("n8_done_ready", 32'(bus8.in_ready), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
